// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing one SRAM-like bus between fetch and data ports
// Single outstanding transaction; the requester not granted last wins a tie.
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_uncached,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic              data_uncached,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_uncached,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic              owner_data_q, owner_data_d;
    logic              last_data_q, last_data_d;
    logic              bus_wr_q, bus_wr_d;
    logic [1:0]        bus_size_q, bus_size_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              bus_unc_q, bus_unc_d;
    logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
    logic              grant_data, grant_inst, capture;

    // On a tie the data port wins unless it was the last one served.
    assign grant_data = data_req && (!inst_req || !last_data_q);
    assign grant_inst = inst_req && !grant_data;

    always_comb begin
        state_d      = state_q;
        owner_data_d = owner_data_q;
        last_data_d  = last_data_q;
        bus_wr_d     = bus_wr_q;
        bus_size_d   = bus_size_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_unc_d    = bus_unc_q;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        bus_req      = 1'b0;
        capture      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_data) begin
                    data_addr_ok = 1'b1;
                    owner_data_d = 1'b1;
                    last_data_d  = 1'b1;
                    bus_wr_d     = data_wr;
                    bus_size_d   = data_size;
                    bus_addr_d   = data_addr;
                    bus_wdata_d  = data_wdata;
                    bus_unc_d    = data_uncached;
                    state_d      = S_ADDR;
                end else if (grant_inst) begin
                    inst_addr_ok = 1'b1;
                    owner_data_d = 1'b0;
                    last_data_d  = 1'b0;
                    bus_wr_d     = 1'b0;
                    bus_size_d   = 2'd2;
                    bus_addr_d   = inst_addr;
                    bus_wdata_d  = '0;
                    bus_unc_d    = inst_uncached;
                    state_d      = S_ADDR;
                end
            end
            S_ADDR: begin
                bus_req = 1'b1;
                if (bus_addr_ok) begin
                    capture = bus_data_ok;
                    state_d = bus_data_ok ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus_data_ok) begin
                    capture = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                inst_data_ok = !owner_data_q;
                data_data_ok = owner_data_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Stores leave the load data register untouched.
    always_comb begin
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        if (capture) begin
            if (!owner_data_q)
                inst_rdata_d = bus_rdata;
            else if (!bus_wr_q)
                data_rdata_d = bus_rdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            owner_data_q <= 1'b0;
            last_data_q  <= 1'b0;
            bus_wr_q     <= 1'b0;
            bus_size_q   <= 2'd0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_unc_q    <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_data_q <= owner_data_d;
            last_data_q  <= last_data_d;
            bus_wr_q     <= bus_wr_d;
            bus_size_q   <= bus_size_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_unc_q    <= bus_unc_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign bus_wr       = bus_wr_q;
    assign bus_size     = bus_size_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;
    assign bus_uncached = bus_unc_q;
    assign inst_rdata   = inst_rdata_q;
    assign data_rdata   = data_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req, inst_uncached, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_uncached, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        bus_req, bus_wr, bus_uncached, bus_addr_ok, bus_data_ok;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_uncached(inst_uncached),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_uncached(data_uncached),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_uncached(bus_uncached),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_addr = 0; inst_uncached = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0; data_uncached = 0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 0;
        tick();
        tick();
        resetn = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 0;
        settle();
        checks++; if ({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok} !== 4'b0) $display("FAIL rst_pulses: got %b want 0000", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}); else passes++;
        checks++; if ({bus_req, bus_wr, bus_uncached, bus_size} !== 5'b0) $display("FAIL rst_bus_ctl: got %b want 00000", {bus_req, bus_wr, bus_uncached, bus_size}); else passes++;
        checks++; if ({bus_addr, bus_wdata} !== 64'b0) $display("FAIL rst_bus_fields: got %h want 0", {bus_addr, bus_wdata}); else passes++;
        checks++; if ({inst_rdata, data_rdata} !== 64'b0) $display("FAIL rst_rdata: got %h want 0", {inst_rdata, data_rdata}); else passes++;
        tick();
        resetn = 1;
        settle();
        checks++; if (bus_req !== 1'b0) $display("FAIL rst_idle_bus_req: got %b want 0", bus_req); else passes++;
    endtask

    task automatic test_inst_fetch();
        do_reset();
        tick();
        inst_req = 1; inst_addr = 32'h1FC0_0000;
        settle();
        checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) $display("FAIL fetch_addr_ok: got %b want 10", {inst_addr_ok, data_addr_ok}); else passes++;
        tick();
        inst_req = 0; bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h3C08_BFC0;
        settle();
        checks++; if ({bus_req, bus_wr, bus_size, bus_addr} !== {1'b1, 1'b0, 2'd2, 32'h1FC0_0000}) $display("FAIL fetch_bus: got %b %b %0d %h want 1 0 2 1fc00000", bus_req, bus_wr, bus_size, bus_addr); else passes++;
        tick();
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
        settle();
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) $display("FAIL fetch_data_ok: got %b want 10", {inst_data_ok, data_data_ok}); else passes++;
        checks++; if (inst_rdata !== 32'h3C08_BFC0) $display("FAIL fetch_rdata: got %h want 3c08bfc0", inst_rdata); else passes++;
        tick();
        settle();
        checks++; if (inst_data_ok !== 1'b0) $display("FAIL fetch_pulse_len: got %b want 0", inst_data_ok); else passes++;
    endtask

    task automatic test_store();
        do_reset();
        tick();
        data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h0000_0080;
        tick();
        data_req = 0; bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h1234_5678;
        tick();
        bus_addr_ok = 0; bus_data_ok = 0;
        settle();
        checks++; if ({data_data_ok, data_rdata} !== {1'b1, 32'h1234_5678}) $display("FAIL load_before_store: got %b %h want 1 12345678", data_data_ok, data_rdata); else passes++;
        tick();
        data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h0000_0100; data_wdata = 32'hDEAD_BEEF;
        settle();
        checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) $display("FAIL store_addr_ok: got %b want 01", {inst_addr_ok, data_addr_ok}); else passes++;
        tick();
        data_req = 0; bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'hBAD0_BAD0;
        settle();
        checks++; if ({bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_uncached} !== {1'b1, 1'b1, 2'd2, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0}) $display("FAIL store_bus: got %b %b %0d %h %h %b", bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_uncached); else passes++;
        tick();
        bus_addr_ok = 0; bus_data_ok = 0;
        settle();
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) $display("FAIL store_data_ok: got %b want 01", {inst_data_ok, data_data_ok}); else passes++;
        checks++; if (data_rdata !== 32'h1234_5678) $display("FAIL store_rdata_kept: got %h want 12345678", data_rdata); else passes++;
    endtask

    task automatic test_round_robin();
        bit          grants[$];
        bit          owners[$];
        logic [31:0] rq[$];
        bit          exp_order[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        bit          o;
        logic [31:0] r;
        int          ndone = 0;
        do_reset();
        for (int c = 0; c < 40 && ndone < 4; c++) begin
            tick();
            inst_req = (grants.size() < 4); data_req = (grants.size() < 4);
            data_wr = 0; data_size = 2;
            inst_addr = 32'h0000_1000 + 32'(grants.size()) * 4;
            data_addr = 32'h0000_2000 + 32'(grants.size()) * 4;
            bus_addr_ok = bus_req; bus_data_ok = bus_req; bus_rdata = $urandom;
            if (bus_req) rq.push_back(bus_rdata);
            settle();
            checks++; if (inst_addr_ok && data_addr_ok) $display("FAIL rr_double_grant: got 11 want at most one"); else passes++;
            if (inst_addr_ok || data_addr_ok) begin
                grants.push_back(data_addr_ok);
                owners.push_back(data_addr_ok);
            end
            if (inst_data_ok || data_data_ok) begin
                ndone++;
                checks++;
                if (owners.size() == 0 || rq.size() == 0) $display("FAIL rr_unexpected_data_ok: got %b%b want none", inst_data_ok, data_data_ok);
                else begin
                    o = owners.pop_front();
                    r = rq.pop_front();
                    if ({inst_data_ok, data_data_ok} !== {~o, o} || (o ? data_rdata : inst_rdata) !== r)
                        $display("FAIL rr_response: got ok=%b%b rdata=%h want ok=%b%b rdata=%h", inst_data_ok, data_data_ok, o ? data_rdata : inst_rdata, ~o, o, r);
                    else passes++;
                end
            end
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= grants.size() || grants[i] !== exp_order[i]) $display("FAIL rr_order_%0d: got %b want %b (1=data)", i, (i < grants.size()) ? grants[i] : 1'bx, exp_order[i]);
            else passes++;
        end
    endtask

    task automatic test_slow_bus();
        do_reset();
        tick();
        data_req = 1; data_wr = 0; data_size = 1; data_addr = 32'h0000_0A42; data_uncached = 0;
        settle();
        checks++; if (data_addr_ok !== 1'b1) $display("FAIL slow_addr_ok: got %b want 1", data_addr_ok); else passes++;
        for (int c = 1; c <= 11; c++) begin
            tick();
            data_req = 0; inst_req = 1; inst_addr = 32'h0000_0400;
            data_addr = 32'hFFFF_FFFF;
            bus_addr_ok = (c == 4); bus_data_ok = (c == 9);
            bus_rdata = (c == 9) ? 32'hCAFE_F00D : $urandom;
            settle();
            if (c <= 10) begin
                checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) $display("FAIL slow_no_grant_c%0d: got %b want 00", c, {inst_addr_ok, data_addr_ok}); else passes++;
            end else begin
                checks++; if (inst_addr_ok !== 1'b1) $display("FAIL slow_next_grant: got %b want 1", inst_addr_ok); else passes++;
            end
            checks++; if (bus_req !== (c <= 4)) $display("FAIL slow_bus_req_c%0d: got %b want %b", c, bus_req, (c <= 4)); else passes++;
            if (c <= 4) begin
                checks++; if ({bus_wr, bus_size, bus_addr} !== {1'b0, 2'd1, 32'h0000_0A42}) $display("FAIL slow_fields_c%0d: got %b %0d %h want 0 1 00000a42", c, bus_wr, bus_size, bus_addr); else passes++;
            end
            checks++; if (data_data_ok !== (c == 10)) $display("FAIL slow_data_ok_c%0d: got %b want %b", c, data_data_ok, (c == 10)); else passes++;
            if (c == 10) begin
                checks++; if (data_rdata !== 32'hCAFE_F00D) $display("FAIL slow_rdata: got %h want cafef00d", data_rdata); else passes++;
            end
        end
        idle_inputs();
    endtask

    task automatic test_uncached_reset();
        do_reset();
        tick();
        data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h1FAF_F000; data_uncached = 1;
        settle();
        checks++; if (data_addr_ok !== 1'b1) $display("FAIL unc_addr_ok: got %b want 1", data_addr_ok); else passes++;
        tick();
        data_req = 0; bus_addr_ok = 1;
        settle();
        checks++; if ({bus_req, bus_uncached, bus_addr} !== {1'b1, 1'b1, 32'h1FAF_F000}) $display("FAIL unc_bus: got %b %b %h want 1 1 1faff000", bus_req, bus_uncached, bus_addr); else passes++;
        tick();
        bus_addr_ok = 0;
        settle();
        checks++; if (bus_req !== 1'b0) $display("FAIL unc_wait_bus_req: got %b want 0", bus_req); else passes++;
        #1 resetn = 0;
        #1;
        checks++; if ({bus_req, bus_uncached, bus_addr, data_data_ok, inst_data_ok} !== 35'b0) $display("FAIL unc_async_reset: got %b %b %h %b %b want all 0", bus_req, bus_uncached, bus_addr, data_data_ok, inst_data_ok); else passes++;
        tick();
        resetn = 1;
        tick();
        bus_data_ok = 1; bus_rdata = 32'h5555_AAAA;
        settle();
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) $display("FAIL unc_late_data_ok: got %b want 00", {inst_data_ok, data_data_ok}); else passes++;
        tick();
        bus_data_ok = 0;
        settle();
        checks++; if ({data_data_ok, data_rdata, bus_req} !== 34'b0) $display("FAIL unc_discarded: got %b %h %b want 0 0 0", data_data_ok, data_rdata, bus_req); else passes++;
    endtask

    task automatic test_spurious();
        do_reset();
        tick();
        bus_data_ok = 1; bus_addr_ok = 1; bus_rdata = 32'h7777_7777;
        settle();
        checks++; if ({inst_data_ok, data_data_ok, bus_req} !== 3'b000) $display("FAIL spur_same_cycle: got %b want 000", {inst_data_ok, data_data_ok, bus_req}); else passes++;
        tick();
        bus_data_ok = 0; bus_addr_ok = 0;
        settle();
        checks++; if ({inst_data_ok, data_data_ok, bus_req} !== 3'b000) $display("FAIL spur_next_cycle: got %b want 000", {inst_data_ok, data_data_ok, bus_req}); else passes++;
        checks++; if ({inst_rdata, data_rdata} !== 64'b0) $display("FAIL spur_rdata: got %h want 0", {inst_rdata, data_rdata}); else passes++;
        tick();
        inst_req = 1; inst_addr = 32'h0000_0040;
        settle();
        checks++; if (inst_addr_ok !== 1'b1) $display("FAIL spur_still_idle: got %b want 1", inst_addr_ok); else passes++;
        tick();
        idle_inputs();
    endtask

    // Timeline model: grant at g, bus address accepted at a, bus data at k, response at k+1.
    task automatic test_random();
        bit          has_txn = 0, own_d = 0, last_d = 0, busy, ig, dg;
        bit          i_p = 0, d_p = 0;
        int          a_cyc = 0, k_cyc = 0, r_cyc = 0, ntx = 0;
        logic [31:0] ia = 0, da = 0, dw = 0, exp_addr = 0, exp_wdata = 0, exp_ir = 0, exp_dr = 0;
        logic        iu = 0, du = 0, dwr = 0, exp_wr = 0, exp_unc = 0;
        logic [1:0]  ds = 0, exp_size = 0;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            busy = has_txn && (cyc <= r_cyc);
            if (!i_p && $urandom_range(0, 2) == 0) begin
                i_p = 1; ia = $urandom; iu = 1'($urandom_range(0, 1));
            end else if (i_p && busy && $urandom_range(0, 15) == 0) i_p = 0;
            if (!d_p && $urandom_range(0, 2) == 0) begin
                d_p = 1; da = $urandom; dw = $urandom; du = 1'($urandom_range(0, 1));
                dwr = 1'($urandom_range(0, 1)); ds = 2'($urandom_range(0, 2));
            end else if (d_p && busy && $urandom_range(0, 15) == 0) d_p = 0;
            inst_req = i_p; inst_addr = ia; inst_uncached = iu;
            data_req = d_p; data_addr = da; data_wdata = dw; data_uncached = du; data_wr = dwr; data_size = ds;
            bus_addr_ok = (busy && (cyc == a_cyc || (cyc > a_cyc && $urandom_range(0, 3) == 0))) || (!busy && $urandom_range(0, 5) == 0);
            bus_data_ok = (busy && (cyc == k_cyc || (cyc == r_cyc && $urandom_range(0, 1) == 0))) || (!busy && $urandom_range(0, 5) == 0);
            bus_rdata = $urandom;
            settle();
            ig = !busy && i_p && (!d_p || last_d);
            dg = !busy && d_p && (!i_p || !last_d);
            checks++; if ({inst_addr_ok, data_addr_ok} !== {ig, dg}) $display("FAIL rnd_addr_ok cyc%0d: got %b want %b", cyc, {inst_addr_ok, data_addr_ok}, {ig, dg}); else passes++;
            checks++; if (bus_req !== (busy && cyc <= a_cyc)) $display("FAIL rnd_bus_req cyc%0d: got %b want %b", cyc, bus_req, (busy && cyc <= a_cyc)); else passes++;
            if (busy && cyc <= a_cyc) begin
                checks++;
                if ({bus_wr, bus_size, bus_addr, bus_uncached} !== {exp_wr, exp_size, exp_addr, exp_unc} || (own_d && bus_wdata !== exp_wdata))
                    $display("FAIL rnd_bus_fields cyc%0d: got %b %0d %h %h %b want %b %0d %h %h %b", cyc, bus_wr, bus_size, bus_addr, bus_wdata, bus_uncached, exp_wr, exp_size, exp_addr, exp_wdata, exp_unc);
                else passes++;
            end
            checks++; if ({inst_data_ok, data_data_ok} !== {busy && cyc == r_cyc && !own_d, busy && cyc == r_cyc && own_d}) $display("FAIL rnd_data_ok cyc%0d: got %b%b want %b%b", cyc, inst_data_ok, data_data_ok, busy && cyc == r_cyc && !own_d, busy && cyc == r_cyc && own_d); else passes++;
            if (busy && cyc == r_cyc) begin
                ntx++;
                checks++; if ((own_d ? data_rdata : inst_rdata) !== (own_d ? exp_dr : exp_ir)) $display("FAIL rnd_rdata cyc%0d: got %h want %h", cyc, own_d ? data_rdata : inst_rdata, own_d ? exp_dr : exp_ir); else passes++;
            end
            if (busy && cyc == k_cyc) begin
                if (!own_d) exp_ir = bus_rdata;
                else if (!exp_wr) exp_dr = bus_rdata;
            end
            if (ig || dg) begin
                has_txn = 1; own_d = dg; last_d = dg;
                a_cyc = cyc + 1 + $urandom_range(0, 3);
                k_cyc = a_cyc + $urandom_range(0, 4);
                r_cyc = k_cyc + 1;
                if (dg) begin
                    exp_wr = dwr; exp_size = ds; exp_addr = da; exp_wdata = dw; exp_unc = du; d_p = 0;
                end else begin
                    exp_wr = 0; exp_size = 2; exp_addr = ia; exp_unc = iu; i_p = 0;
                end
            end
        end
        idle_inputs();
        checks++; if (ntx < 100) $display("FAIL rnd_throughput: got %0d transactions want at least 100", ntx); else passes++;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_inst_fetch();
        test_store();
        test_round_robin();
        test_slow_bus();
        test_uncached_reset();
        test_spurious();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
